cmac_approx_mul_pipe: RTL and testbench

Parametrised, pipelined, multi-lane signed multiplier array for the CMAC datapath.
- Successor to the fixed 8-bit approximate multiplier; selects exact or approximate arithmetic per transaction.
- Each lane decomposes operands into SUB_W-bit unsigned sub-products.
- Sits between the CSC operand feed and the CMAC adder tree; uses a valid/ready handshake with full backpressure.

---
 rtl/cmac_approx_mul_defines.sv | 20 ++
 rtl/cmac_approx_mul_lane.sv | 112 +++++++++++
 rtl/mult4x4.sv | 10 +
 rtl/cmac_approx_mul_pipe.sv | 88 ++++++++
 tb/tb_cmac_approx_mul_pipe.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmac_approx_mul_defines.sv
// Shared constants for the CMAC approximate multiplier array: mode encodings,
// sub-multiplier width and pipeline depth.
package cmac_approx_mul_defines;

    localparam int SUB_W      = 4;
    localparam int PIPE_DEPTH = 3;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_EXACT        = 2'd0;
    localparam mode_t MODE_APPROX_1C    = 2'd1;
    localparam mode_t MODE_APPROX_TRUNC = 2'd2;
    localparam mode_t MODE_RSVD         = 2'd3;

    // The reserved encoding falls back to exact arithmetic.
    function automatic logic is_exact(input mode_t m);
        return (m == MODE_EXACT) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/cmac_approx_mul_lane.sv
// One signed multiplier lane: sign/magnitude split (S1), nibble sub-products (S2),
// shifted accumulation with mode-dependent sign restore (S3).
module cmac_approx_mul_lane
    import cmac_approx_mul_defines::*;
#(
    parameter int DATA_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ld1,
    input  logic                i_ld2,
    input  logic                i_ld3,
    input  mode_t               i_mode_in,
    input  mode_t               i_mode_s1,
    input  mode_t               i_mode_s2,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_prod
);

    localparam int K     = DATA_W / NIB_W;
    localparam int MAG_W = DATA_W + 1;
    localparam int PW    = 2 * DATA_W;
    localparam int NPP   = K * K;

    logic [MAG_W-1:0] w_a_ext;
    logic [MAG_W-1:0] w_b_ext;
    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;
    logic             r_sign1;
    logic [MAG_W-1:0] r_mag_a;
    logic [MAG_W-1:0] r_mag_b;
    logic [7:0]       w_pp [NPP];
    logic [7:0]       r_pp [NPP];
    logic [PW-1:0]    w_corr;
    logic [PW-1:0]    r_corr;
    logic             r_sign2;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_res;
    logic [PW-1:0]    r_prod;

    assign w_a_ext = {i_a[DATA_W-1], i_a};
    assign w_b_ext = {i_b[DATA_W-1], i_b};

    // Exact modes negate (so -2^(DATA_W-1) needs the extra bit); approximate modes only invert.
    always_comb begin
        w_mag_a = w_a_ext;
        w_mag_b = w_b_ext;
        if (i_a[DATA_W-1]) w_mag_a = is_exact(i_mode_in) ? -w_a_ext : ~w_a_ext;
        if (i_b[DATA_W-1]) w_mag_b = is_exact(i_mode_in) ? -w_b_ext : ~w_b_ext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sign1 <= 1'b0;
            r_mag_a <= '0;
            r_mag_b <= '0;
        end else if (i_ld1) begin
            r_sign1 <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            mult4x4 u_mult (
                .i_a (r_mag_a[gi*NIB_W +: NIB_W]),
                .i_b (r_mag_b[gj*NIB_W +: NIB_W]),
                .o_p (w_pp[gi*K + gj])
            );
        end
    end

    // Cross terms for the magnitude bit above the nibbles; both set at once cannot occur.
    always_comb begin
        w_corr = '0;
        if (r_mag_a[DATA_W]) w_corr = w_corr + (PW'(r_mag_b[DATA_W-1:0]) << DATA_W);
        if (r_mag_b[DATA_W]) w_corr = w_corr + (PW'(r_mag_a[DATA_W-1:0]) << DATA_W);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NPP; n++) r_pp[n] <= '0;
            r_corr  <= '0;
            r_sign2 <= 1'b0;
        end else if (i_ld2) begin
            for (int n = 0; n < NPP; n++)
                r_pp[n] <= (n == 0 && i_mode_s1 == MODE_APPROX_TRUNC) ? 8'h00 : w_pp[n];
            r_corr  <= w_corr;
            r_sign2 <= r_sign1;
        end
    end

    always_comb begin
        w_sum = r_corr;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w_sum = w_sum + (PW'(r_pp[i*K + j]) << (NIB_W * (i + j)));
        w_res = w_sum;
        if (r_sign2) w_res = is_exact(i_mode_s2) ? -w_sum : ~w_sum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prod <= '0;
        else if (i_ld3) r_prod <= w_res;
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/mult4x4.sv
// 4x4 unsigned multiplier with an 8-bit product; the building block of every lane.
module mult4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

// File: rtl/cmac_approx_mul_pipe.sv
// Multi-lane pipelined signed multiplier with per-transaction exact/approximate mode,
// three register stages and a fully back-pressured valid/ready handshake.
module cmac_approx_mul_pipe #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int SUB_W  = cmac_approx_mul_defines::SUB_W
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic [1:0]                in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*2*DATA_W-1:0] out_data,
    output logic [1:0]                out_mode,
    output logic                      err_mode
);

    logic       r_v1;
    logic       r_v2;
    logic       r_v3;
    logic [1:0] r_mode1;
    logic [1:0] r_mode2;
    logic [1:0] r_mode3;
    logic       r_err;
    logic       w_en1;
    logic       w_en2;
    logic       w_en3;
    logic       w_acc;
    logic       w_ld2;
    logic       w_ld3;

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_en3 = !r_v3 || out_ready;
    assign w_en2 = !r_v2 || w_en3;
    assign w_en1 = !r_v1 || w_en2;
    assign w_acc = in_valid && w_en1;
    assign w_ld2 = w_en2 && r_v1;
    assign w_ld3 = w_en3 && r_v2;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_mode1 <= '0;
            r_mode2 <= '0;
            r_mode3 <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
            if (w_acc) r_mode1 <= in_mode;
            if (w_ld2) r_mode2 <= r_mode1;
            if (w_ld3) r_mode3 <= r_mode2;
            if (w_acc && in_mode == cmac_approx_mul_defines::MODE_RSVD) r_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cmac_approx_mul_lane #(
            .DATA_W (DATA_W),
            .NIB_W  (SUB_W)
        ) u_lane (
            .i_clk     (nvdla_core_clk),
            .i_rst_n   (nvdla_core_rstn),
            .i_ld1     (w_acc),
            .i_ld2     (w_ld2),
            .i_ld3     (w_ld3),
            .i_mode_in (in_mode),
            .i_mode_s1 (r_mode1),
            .i_mode_s2 (r_mode2),
            .i_a       (in_a[g*DATA_W +: DATA_W]),
            .i_b       (in_b[g*DATA_W +: DATA_W]),
            .o_prod    (out_data[g*2*DATA_W +: 2*DATA_W])
        );
    end

    assign in_ready  = w_en1;
    assign out_valid = r_v3;
    assign out_mode  = r_mode3;
    assign err_mode  = r_err;

endmodule

// File: tb/tb_cmac_approx_mul_pipe.sv
// Self-checking bench: directed vector table, backpressure/reset sequences and a
// randomized scoreboard against a plain-arithmetic reference model.
module tb_cmac_approx_mul_pipe;

    typedef struct {
        logic [7:0]  a0, b0, a1, b1;
        logic [1:0]  mode;
        logic [15:0] exp0, exp1;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   mode;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         inValid, inReady, outValid, outReady, errMode;
    logic [63:0]  inA, inB;
    logic [1:0]   inMode, outMode;
    logic [127:0] outData;
    logic         inValid16, inReady16, outValid16, outReady16, errMode16;
    logic [31:0]  inA16, inB16;
    logic [1:0]   inMode16, outMode16;
    logic [63:0]  outData16;

    int   tests = 0;
    int   errors = 0;
    exp_t expQ8[$];
    logic [63:0] expQ16[$];

    always #5 clk = ~clk;

    cmac_approx_mul_pipe #(.DATA_W(8), .LANES(8)) dut8 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB), .in_mode(inMode),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .out_mode(outMode), .err_mode(errMode)
    );

    cmac_approx_mul_pipe #(.DATA_W(16), .LANES(2)) dut16 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_valid(inValid16), .in_ready(inReady16), .in_a(inA16), .in_b(inB16), .in_mode(inMode16),
        .out_valid(outValid16), .out_ready(outReady16), .out_data(outData16),
        .out_mode(outMode16), .err_mode(errMode16)
    );

    // Reference: signed value arithmetic; approximate modes use one's-complement magnitudes.
    function automatic longint refMul(input int dw, input longint a, input longint b, input logic [1:0] mode);
        longint av, bv, ma, mb, s, p;
        av = (a >= (longint'(1) << (dw - 1))) ? a - (longint'(1) << dw) : a;
        bv = (b >= (longint'(1) << (dw - 1))) ? b - (longint'(1) << dw) : b;
        if (mode == 2'd0 || mode == 2'd3) begin
            p = av * bv;
        end else begin
            ma = (av < 0) ? -av - 1 : av;
            mb = (bv < 0) ? -bv - 1 : bv;
            s  = ma * mb;
            if (mode == 2'd2) s = s - (ma % 16) * (mb % 16);
            p  = ((av < 0) != (bv < 0)) ? -s - 1 : s;
        end
        return p & ((longint'(1) << (2 * dw)) - 1);
    endfunction

    function automatic logic [127:0] expVec8(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m);
        logic [127:0] e;
        longint p;
        e = '0;
        for (int l = 0; l < 8; l++) begin
            p = refMul(8, longint'(a[l*8 +: 8]), longint'(b[l*8 +: 8]), m);
            e[l*16 +: 16] = p[15:0];
        end
        return e;
    endfunction

    function automatic logic [63:0] expVec16(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        logic [63:0] e;
        longint p;
        for (int l = 0; l < 2; l++) begin
            p = refMul(16, longint'(a[l*16 +: 16]), longint'(b[l*16 +: 16]), m);
            e[l*32 +: 32] = p[31:0];
        end
        return e;
    endfunction

    function automatic logic [7:0] pickByte();
        case ($urandom % 8)
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            3: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] pickWord();
        logic [63:0] w;
        for (int l = 0; l < 8; l++) w[l*8 +: 8] = pickByte();
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Single transaction into an otherwise idle dut8; returns cycles until out_valid.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m, output int lat);
        inA = a; inB = b; inMode = m; inValid = 1'b1;
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) inValid = 1'b0;
            if (outValid) begin
                lat = c;
                break;
            end
        end
    endtask

    // Scoreboard: handshakes sampled mid-cycle, between driving edges.
    always @(negedge clk) begin
        if (!rstn) begin
            expQ8.delete();
            expQ16.delete();
        end else begin
            if (outValid && outReady) begin
                if (expQ8.size() == 0) checkOutput("sb8 unexpected output", 1, 0);
                else begin
                    exp_t e;
                    e = expQ8.pop_front();
                    checkOutput("sb8 data", outData, e.data);
                    checkOutput("sb8 mode", 128'(outMode), 128'(e.mode));
                end
            end
            if (inValid && inReady) begin
                exp_t e;
                e.data = expVec8(inA, inB, inMode);
                e.mode = inMode;
                expQ8.push_back(e);
            end
            if (outValid16 && outReady16) begin
                if (expQ16.size() == 0) checkOutput("sb16 unexpected output", 1, 0);
                else checkOutput("sb16 data", 128'(outData16), 128'(expQ16.pop_front()));
            end
            if (inValid16 && inReady16) expQ16.push_back(expVec16(inA16, inB16, inMode16));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [63:0] a, b;
        logic [63:0] bpA[4], bpB[4];
        logic [127:0] bpExp[4];
        int          lat, idx, accepted, stale;
        logic        ready, errSeen;

        vecs[0] = '{a0:8'h80, b0:8'h80, a1:8'h80, b1:8'h01, mode:2'd0, exp0:16'h4000, exp1:16'hFF80};
        vecs[1] = '{a0:8'hFF, b0:8'h05, a1:8'h80, b1:8'h01, mode:2'd1, exp0:16'hFFFF, exp1:16'hFF80};
        vecs[2] = '{a0:8'h03, b0:8'h05, a1:8'h7F, b1:8'h7F, mode:2'd1, exp0:16'h000F, exp1:16'h3F01};
        vecs[3] = '{a0:8'h03, b0:8'h05, a1:8'h12, b1:8'h34, mode:2'd2, exp0:16'h0000, exp1:16'h03A0};
        vecs[4] = '{a0:8'h02, b0:8'h03, a1:8'hFF, b1:8'hFF, mode:2'd3, exp0:16'h0006, exp1:16'h0001};
        vecs[5] = '{a0:8'h7F, b0:8'h80, a1:8'h00, b1:8'h80, mode:2'd0, exp0:16'hC080, exp1:16'h0000};

        rstn = 1'b0;
        inValid = 0; inA = '0; inB = '0; inMode = '0; outReady = 1'b1;
        inValid16 = 0; inA16 = '0; inB16 = '0; inMode16 = '0; outReady16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 128'(outValid), 0);
        checkOutput("reset out_data", outData, 0);
        checkOutput("reset out_mode", 128'(outMode), 0);
        checkOutput("reset err_mode", 128'(errMode), 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready after reset", 128'(inReady), 1);

        // Directed table
        errSeen = 1'b0;
        for (int v = 0; v < 6; v++) begin
            a = pickWord(); b = pickWord();
            a[15:0] = {vecs[v].a1, vecs[v].a0};
            b[15:0] = {vecs[v].b1, vecs[v].b0};
            applyStimulus(a, b, vecs[v].mode, lat);
            errSeen = errSeen | (vecs[v].mode == 2'd3);
            checkOutput($sformatf("vec%0d latency", v), 128'(lat), 3);
            checkOutput($sformatf("vec%0d lane0", v), 128'(outData[15:0]), 128'(vecs[v].exp0));
            checkOutput($sformatf("vec%0d lane1", v), 128'(outData[31:16]), 128'(vecs[v].exp1));
            checkOutput($sformatf("vec%0d out_mode", v), 128'(outMode), 128'(vecs[v].mode));
            checkOutput($sformatf("vec%0d err_mode", v), 128'(errMode), 128'(errSeen));
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: four transactions against a stalled output
        for (int k = 0; k < 4; k++) begin
            bpA[k] = pickWord(); bpB[k] = pickWord();
            bpA[k][7:0] = 8'(k + 1);
            bpExp[k] = expVec8(bpA[k], bpB[k], 2'd0);
        end
        outReady = 1'b0; idx = 0; accepted = 0;
        inA = bpA[0]; inB = bpB[0]; inMode = 2'd0; inValid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 ready = inReady;
            @(posedge clk); #1;
            if (ready) begin
                accepted++;
                idx++;
                if (idx < 4) begin inA = bpA[idx]; inB = bpB[idx]; end
            end
        end
        checkOutput("bp accepted count", 128'(accepted), 3);
        checkOutput("bp in_ready stalled", 128'(inReady), 0);
        checkOutput("bp out_valid stalled", 128'(outValid), 1);
        for (int c = 0; c < 2; c++) begin
            checkOutput("bp held out_data", outData, bpExp[0]);
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp in_ready on release", 128'(inReady), 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bp drain%0d valid", k), 128'(outValid), 1);
            checkOutput($sformatf("bp drain%0d data", k), outData, bpExp[k]);
            @(posedge clk); #1;
            if (k == 0) inValid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset with transactions in flight
        outReady = 1'b0;
        inA = pickWord(); inB = pickWord(); inMode = 2'd0; inValid = 1'b1;
        @(posedge clk); #1;
        inA = pickWord(); inB = pickWord();
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("pre-reset out_valid", 128'(outValid), 1);
        checkOutput("err_mode sticky", 128'(errMode), 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async reset out_valid", 128'(outValid), 0);
        checkOutput("async reset err_mode", 128'(errMode), 0);
        checkOutput("async reset out_data", outData, 0);
        @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        outReady = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (outValid) stale++;
        end
        checkOutput("no stale output after reset", 128'(stale), 0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            inValid = 1'($urandom % 2);
            inA = pickWord(); inB = pickWord();
            inMode = 2'($urandom % 4);
            outReady = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        inValid = 1'b0; outReady = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("sb8 queue drained", 128'(expQ8.size()), 0);

        // Wide configuration
        inA16 = {16'h7FFF, 16'h8000}; inB16 = {16'h8000, 16'h8000}; inMode16 = 2'd0; inValid16 = 1'b1;
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) inValid16 = 1'b0;
            if (outValid16) begin
                lat = c;
                break;
            end
        end
        checkOutput("w16 latency", 128'(lat), 3);
        checkOutput("w16 lane0 min*min", 128'(outData16[31:0]), 128'(32'h40000000));
        checkOutput("w16 lane1 max*min", 128'(outData16[63:32]), 128'(32'hC0008000));
        for (int c = 0; c < 150; c++) begin
            inValid16 = 1'($urandom % 4 != 0);
            inA16 = $urandom; inB16 = $urandom;
            if (c % 10 == 0) inA16[15:0] = 16'h8000;
            if (c % 10 == 5) inB16[31:16] = 16'h7FFF;
            inMode16 = 2'd0;
            outReady16 = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        inValid16 = 1'b0; outReady16 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("sb16 queue drained", 128'(expQ16.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
